// File: rtl/draw_board_if.sv
// VGA stream bundle: pixel position, sync, blanking and colour.
//   hcount/vcount : 11-bit pixel position
//   hsync/vsync   : sync pulses
//   hblnk/vblnk   : blanking flags
//   rgb           : 12-bit colour (4 bits per channel)
// master drives the stream, slave receives it.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_board.sv
// Minesweeper board painter: overlays the tile grid (borders plus per-tile
// state colour) on the incoming VGA stream with a fixed 2-cycle latency.
// Owns the tile-state array, updated through a write port, and a sequential
// clear engine that returns every tile to hidden.
//   clk, rst      : pixel clock, synchronous active-high reset
//   in / out      : VGA stream in / painted VGA stream out (2 clk later)
//   wr_en, wr_col, wr_row, wr_state : tile write port (0 hidden, 1 revealed,
//                   2 flagged, 3 exploded)
//   clear         : pulse starting a board clear sweep
//   busy          : high while the sweep runs
// Optional macro DRAW_BOARD_HOVER_EN adds hover_col/hover_row inputs that
// lighten the hovered hidden tile.
module draw_board #(
  parameter int unsigned GRID_COLS = 8,
  parameter int unsigned GRID_ROWS = 8,
  parameter int unsigned TILE_SIZE = 32,
  parameter int unsigned BOARD_X   = 192,
  parameter int unsigned BOARD_Y   = 64
) (
  input  logic       clk,
  input  logic       rst,
  vga_if.slave       in,
  vga_if.master      out,
  input  logic       wr_en,
  input  logic [3:0] wr_col,
  input  logic [3:0] wr_row,
  input  logic [1:0] wr_state,
  input  logic       clear,
`ifdef DRAW_BOARD_HOVER_EN
  input  logic [3:0] hover_col,
  input  logic [3:0] hover_row,
`endif
  output logic       busy
);
  localparam int unsigned NUM_TILES   = GRID_COLS * GRID_ROWS;
  localparam int unsigned IDX_W       = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam int unsigned TILE_SH     = $clog2(TILE_SIZE);
  localparam int unsigned BOARD_X_END = BOARD_X + GRID_COLS * TILE_SIZE;
  localparam int unsigned BOARD_Y_END = BOARD_Y + GRID_ROWS * TILE_SIZE;

  localparam logic [1:0]  ST_HIDDEN   = 2'd0;
  localparam logic [1:0]  ST_REVEALED = 2'd1;
  localparam logic [1:0]  ST_FLAGGED  = 2'd2;

  localparam logic [11:0] C_BORDER    = 12'h444;
  localparam logic [11:0] C_HIDDEN    = 12'h888;
  localparam logic [11:0] C_REVEALED  = 12'hCCC;
  localparam logic [11:0] C_FLAGGED   = 12'hF80;
  localparam logic [11:0] C_EXPLODED  = 12'hF00;
`ifdef DRAW_BOARD_HOVER_EN
  localparam logic [11:0] C_HOVER     = 12'hAAA;
`endif

  typedef enum logic [0:0] {IDLE, SWEEP} state_t;

  // Stage 1: board-relative geometry
  logic [11:0] rel_x_c, rel_y_c;
  logic        in_board_c;

  assign rel_x_c    = {1'b0, in.hcount} - 12'(BOARD_X);
  assign rel_y_c    = {1'b0, in.vcount} - 12'(BOARD_Y);
  assign in_board_c = (32'(in.hcount) >= BOARD_X) && (32'(in.hcount) < BOARD_X_END) &&
                      (32'(in.vcount) >= BOARD_Y) && (32'(in.vcount) < BOARD_Y_END);

  logic [10:0] hcount_q, vcount_q;
  logic        hsync_q, vsync_q, hblnk_q, vblnk_q;
  logic [11:0] rgb_q;
  logic        in_board_q, border_q;
  logic [3:0]  col_q, row_q;
`ifdef DRAW_BOARD_HOVER_EN
  logic [3:0]  hover_col_q, hover_row_q;
`endif

  // col/row only matter inside the board, where they always fit in 4 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q   <= '0;
      vcount_q   <= '0;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      hblnk_q    <= 1'b0;
      vblnk_q    <= 1'b0;
      rgb_q      <= '0;
      in_board_q <= 1'b0;
      border_q   <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
`ifdef DRAW_BOARD_HOVER_EN
      hover_col_q <= '0;
      hover_row_q <= '0;
`endif
    end else begin
      hcount_q   <= in.hcount;
      vcount_q   <= in.vcount;
      hsync_q    <= in.hsync;
      vsync_q    <= in.vsync;
      hblnk_q    <= in.hblnk;
      vblnk_q    <= in.vblnk;
      rgb_q      <= in.rgb;
      in_board_q <= in_board_c;
      border_q   <= (rel_x_c[TILE_SH-1:0] == '0) || (rel_y_c[TILE_SH-1:0] == '0);
      col_q      <= 4'(rel_x_c >> TILE_SH);
      row_q      <= 4'(rel_y_c >> TILE_SH);
`ifdef DRAW_BOARD_HOVER_EN
      hover_col_q <= hover_col;
      hover_row_q <= hover_row;
`endif
    end
  end

  // Tile array and clear sweep
  logic [1:0]       tiles [NUM_TILES];
  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_d;
  logic             wr_ok_c;
  logic [IDX_W-1:0] wr_idx_c;

  assign wr_ok_c  = wr_en && !busy &&
                    (32'(wr_col) < GRID_COLS) && (32'(wr_row) < GRID_ROWS);
  assign wr_idx_c = IDX_W'(32'(wr_row) * GRID_COLS + 32'(wr_col));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy    <= busy_d;
    end
  end

  // Sweep sequencing: one tile per cycle, clear ignored while sweeping
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = SWEEP;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      SWEEP: begin
        if (32'(idx_q) == NUM_TILES - 1) begin
          state_d = IDLE;
          idx_d   = '0;
          busy_d  = 1'b0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // A write issued with clear in the same idle cycle lands first; the sweep
  // then overwrites it.
  always_ff @(posedge clk) begin
    if (rst) begin
      tiles <= '{default: ST_HIDDEN};
    end else if (state_q == SWEEP) begin
      tiles[idx_q] <= ST_HIDDEN;
    end else if (wr_ok_c) begin
      tiles[wr_idx_c] <= wr_state;
    end
  end

  // Stage 2: colour selection
  logic [IDX_W-1:0] rd_idx_c;
  logic [1:0]       tile_c;
  logic [11:0]      rgb_c;

  assign rd_idx_c = IDX_W'(32'(row_q) * GRID_COLS + 32'(col_q));
  assign tile_c   = tiles[rd_idx_c];

  always_comb begin
    rgb_c = rgb_q;
    if (hblnk_q || vblnk_q) begin
      rgb_c = 12'h000;
    end else if (!in_board_q) begin
      rgb_c = rgb_q;
    end else if (border_q) begin
      rgb_c = C_BORDER;
    end else begin
      case (tile_c)
`ifdef DRAW_BOARD_HOVER_EN
        ST_HIDDEN:   rgb_c = (hover_col_q == col_q && hover_row_q == row_q) ? C_HOVER : C_HIDDEN;
`else
        ST_HIDDEN:   rgb_c = C_HIDDEN;
`endif
        ST_REVEALED: rgb_c = C_REVEALED;
        ST_FLAGGED:  rgb_c = C_FLAGGED;
        default:     rgb_c = C_EXPLODED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out.hcount <= '0;
      out.vcount <= '0;
      out.hsync  <= 1'b0;
      out.vsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      out.hcount <= hcount_q;
      out.vcount <= vcount_q;
      out.hsync  <= hsync_q;
      out.vsync  <= vsync_q;
      out.hblnk  <= hblnk_q;
      out.vblnk  <= vblnk_q;
      out.rgb    <= rgb_c;
    end
  end
endmodule

// File: tb/tb_draw_board.sv
// Randomized scoreboard bench for draw_board: a driver issues pixels, tile
// writes, clears and resets while updating a tile-map model; a monitor pops
// time-tagged expectations and compares them with the DUT outputs.
module tb_draw_board;
  localparam int COLS = 8;
  localparam int ROWS = 8;
  localparam int TS   = 32;
  localparam int BX   = 192;
  localparam int BY   = 64;
  localparam int NT   = COLS * ROWS;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [3:0] wr_col, wr_row;
  logic [1:0] wr_state;
  logic       clear;
  logic       busy;
`ifdef DRAW_BOARD_HOVER_EN
  logic [3:0] hover_col, hover_row;
  int         hv_c = 15;
  int         hv_r = 15;
`endif

  vga_if vin ();
  vga_if vout ();

  draw_board #(.GRID_COLS(COLS), .GRID_ROWS(ROWS), .TILE_SIZE(TS),
               .BOARD_X(BX), .BOARD_Y(BY)) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (vin),
    .out      (vout),
    .wr_en    (wr_en),
    .wr_col   (wr_col),
    .wr_row   (wr_row),
    .wr_state (wr_state),
    .clear    (clear),
`ifdef DRAW_BOARD_HOVER_EN
    .hover_col(hover_col),
    .hover_row(hover_row),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [10:0] h, v;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
  } pix_t;

  typedef struct {
    int   due;
    logic busy;
  } bsy_t;

  pix_t pq[$];
  bsy_t bq[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  // Reference model: tile map plus clear-sweep progress
  int   tiles_m [NT];
  bit   m_busy = 1'b0;
  int   m_pos  = 0;

  function automatic logic [11:0] exp_rgb(int h, int v, bit hb, bit vb, logic [11:0] rin);
    int rx, ry, c, r, st;
    if (hb || vb) return 12'h000;
    if (h < BX || h >= BX + COLS * TS || v < BY || v >= BY + ROWS * TS) return rin;
    rx = h - BX;
    ry = v - BY;
    if (rx % TS == 0 || ry % TS == 0) return 12'h444;
    c  = rx / TS;
    r  = ry / TS;
    st = tiles_m[r * COLS + c];
    case (st)
`ifdef DRAW_BOARD_HOVER_EN
      0: return (hv_c == c && hv_r == r) ? 12'hAAA : 12'h888;
`else
      0: return 12'h888;
`endif
      1: return 12'hCCC;
      2: return 12'hF80;
      default: return 12'hF00;
    endcase
  endfunction

  // One clock of stimulus; updates the model for the coming edge and queues
  // the busy value after that edge and the pixel two edges later.
  task automatic step(input int h, input int v, input bit hb, input bit vb,
                      input bit we, input int wc, input int wrw, input int ws,
                      input bit clr, input bit r);
    pix_t p, z;
    bsy_t b;
    logic [11:0] rin;
    logic hs, vs;
    @(negedge clk);
    rin = 12'($urandom);
    hs  = 1'($urandom);
    vs  = 1'($urandom);
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hsync  = hs;
    vin.vsync  = vs;
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.rgb    = rin;
    wr_en      = we;
    wr_col     = 4'(wc);
    wr_row     = 4'(wrw);
    wr_state   = 2'(ws);
    clear      = clr;
    rst        = r;
`ifdef DRAW_BOARD_HOVER_EN
    hover_col  = 4'(hv_c);
    hover_row  = 4'(hv_r);
`endif
    if (r) begin
      for (int i = 0; i < NT; i++) tiles_m[i] = 0;
      m_busy = 1'b0;
      m_pos  = 0;
    end else if (m_busy) begin
      tiles_m[m_pos] = 0;
      m_pos++;
      if (m_pos == NT) m_busy = 1'b0;
    end else begin
      if (we && wc < COLS && wrw < ROWS) tiles_m[wrw * COLS + wc] = ws;
      if (clr) begin
        m_busy = 1'b1;
        m_pos  = 0;
      end
    end
    b.due  = cyc + 1;
    b.busy = m_busy;
    bq.push_back(b);
    z = '{due: 0, h: '0, v: '0, hs: 1'b0, vs: 1'b0, hb: 1'b0, vb: 1'b0, rgb: '0};
    if (r) begin
      if (pq.size() > 0 && pq[pq.size()-1].due == cyc + 1) begin
        z.due = cyc + 1;
        pq[pq.size()-1] = z;
      end
      p = z;
      p.due = cyc + 2;
    end else begin
      p = '{due: cyc + 2, h: 11'(h), v: 11'(v), hs: hs, vs: vs, hb: hb, vb: vb,
            rgb: exp_rgb(h, v, hb, vb, rin)};
    end
    pq.push_back(p);
  endtask

  task automatic rnd_step(input bit we, input int wc, input int wrw, input int ws,
                          input bit clr, input bit r);
    int h, v;
    bit hb, vb;
    h  = ($urandom_range(3, 0) != 0) ? int'($urandom_range(460, 180)) : int'($urandom_range(2047, 0));
    v  = ($urandom_range(3, 0) != 0) ? int'($urandom_range(330, 50)) : int'($urandom_range(2047, 0));
    hb = ($urandom_range(9, 0) == 0);
    vb = ($urandom_range(9, 0) == 0);
    step(h, v, hb, vb, we, wc, wrw, ws, clr, r);
  endtask

  task automatic pix(input int h, input int v, input bit blank);
    step(h, v, blank, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic write_tile(input int c, input int r, input int s);
    rnd_step(1'b1, c, r, s, 1'b0, 1'b0);
  endtask

  task automatic scan_centres();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        pix(BX + c * TS + TS / 2, BY + r * TS + TS / 2, 1'b0);
  endtask

  // Monitor: compares every expectation when its cycle arrives
  initial begin
    pix_t p;
    bsy_t b;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (pq.size() > 0 && pq[0].due <= cyc) begin
        p = pq.pop_front();
        checks++;
        if (p.due < cyc) begin
          failures++;
          $display("FAIL pix_late due=%0d now=%0d", p.due, cyc);
        end else if (vout.hcount !== p.h || vout.vcount !== p.v || vout.hsync !== p.hs ||
                     vout.vsync !== p.vs || vout.hblnk !== p.hb || vout.vblnk !== p.vb) begin
          failures++;
          $display("FAIL timing cyc=%0d got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b exp h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b",
                   cyc, vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk,
                   p.h, p.v, p.hs, p.vs, p.hb, p.vb);
        end
        checks++;
        if (vout.rgb !== p.rgb) begin
          failures++;
          $display("FAIL rgb cyc=%0d pixel=(%0d,%0d) got %h exp %h", cyc, p.h, p.v, vout.rgb, p.rgb);
        end
      end
      while (bq.size() > 0 && bq[0].due <= cyc) begin
        b = bq.pop_front();
        checks++;
        if (b.due != cyc || busy !== b.busy) begin
          failures++;
          $display("FAIL busy cyc=%0d due=%0d got %b exp %b", cyc, b.due, busy, b.busy);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NT; i++) tiles_m[i] = 0;
    rst = 1'b1; wr_en = 1'b0; wr_col = '0; wr_row = '0; wr_state = '0; clear = 1'b0;
    vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
    vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;
`ifdef DRAW_BOARD_HOVER_EN
    hover_col = 4'hF; hover_row = 4'hF;
`endif
    repeat (3) rnd_step(1'b0, 0, 0, 0, 1'b0, 1'b1);

    // Fresh board, blanking and pass-through
    pix(193, 65, 1'b0);
    pix(0, 0, 1'b1);
    pix(0, 0, 1'b0);
    repeat (150) rnd_step(1'b0, 0, 0, 0, 1'b0, 1'b0);

    // Explode tile (2,1); inner pixel and border pixel
    write_tile(2, 1, 3);
    pix(BX + 2 * TS + 5, BY + TS + 5, 1'b0);
    pix(256, 100, 1'b0);

    // Out-of-range writes change nothing
    write_tile(8, 0, 2);
    write_tile(0, 8, 1);
    scan_centres();

    // Random writes, including out-of-range coordinates
    repeat (60) rnd_step(1'b1, $urandom_range(9, 0), $urandom_range(9, 0), $urandom_range(3, 0), 1'b0, 1'b0);
    scan_centres();

    // Flag four tiles, then clear with a write in the same cycle
    write_tile(1, 1, 2);
    write_tile(3, 4, 2);
    write_tile(7, 7, 2);
    write_tile(0, 6, 2);
    rnd_step(1'b1, 5, 5, 1, 1'b1, 1'b0);
    for (int i = 0; i < 70; i++) begin
      if (i == 10) rnd_step(1'b0, 0, 0, 0, 1'b1, 1'b0);
      else if (i >= 20 && i < 26) rnd_step(1'b1, $urandom_range(7, 0), $urandom_range(7, 0), 3, 1'b0, 1'b0);
      else rnd_step(1'b0, 0, 0, 0, 1'b0, 1'b0);
    end
    scan_centres();

    // Reset in the middle of a sweep
    for (int i = 0; i < 10; i++) write_tile($urandom_range(7, 0), $urandom_range(7, 0), $urandom_range(3, 1));
    rnd_step(1'b0, 0, 0, 0, 1'b1, 1'b0);
    repeat (30) rnd_step(1'b0, 0, 0, 0, 1'b0, 1'b0);
    rnd_step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    scan_centres();

`ifdef DRAW_BOARD_HOVER_EN
    hv_c = 0; hv_r = 0;
    pix(200, 70, 1'b0);
    write_tile(0, 0, 2);
    pix(200, 70, 1'b0);
`endif

    // Random mix of everything
    for (int i = 0; i < 400; i++) begin
`ifdef DRAW_BOARD_HOVER_EN
      hv_c = $urandom_range(9, 0);
      hv_r = $urandom_range(9, 0);
`endif
      rnd_step($urandom_range(2, 0) == 0, $urandom_range(9, 0), $urandom_range(9, 0),
               $urandom_range(3, 0), $urandom_range(80, 0) == 0, $urandom_range(300, 0) == 0);
    end

    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (pq.size() != 0 || bq.size() != 0) begin
      failures++;
      $display("FAIL drain pending_pix=%0d pending_busy=%0d exp 0", pq.size(), bq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
